// File: rtl/display_share_arbiter.sv
// display_share_arbiter: round-robin time-share of a two-digit seven-segment display
// between two requesters, with a fixed hold time, done pulse and one blank gap cycle.
module display_6bit (
  input  logic [5:0] val,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);
  logic [3:0] tens, units;
  function automatic logic [6:0] digit(input logic [3:0] d);
    case (d)
      4'd0: digit = 7'b0000001;
      4'd1: digit = 7'b1001111;
      4'd2: digit = 7'b0010010;
      4'd3: digit = 7'b0000110;
      4'd4: digit = 7'b1001100;
      4'd5: digit = 7'b0100100;
      4'd6: digit = 7'b0100000;
      4'd7: digit = 7'b0001111;
      4'd8: digit = 7'b0000000;
      4'd9: digit = 7'b0000100;
      default: digit = 7'b1111111;
    endcase
  endfunction
  assign tens = 4'(val / 6'd10);
  assign units = 4'(val % 6'd10);
  assign seg_tens = digit(tens);
  assign seg_units = digit(units);
endmodule

module display_share_arbiter #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [5:0] val0,
  input  logic [5:0] val1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] shown_val_q, shown_val_d;
  logic owner_q, owner_d, last_owner_q, last_owner_d;
  logic win, show;
  logic [6:0] dec_tens, dec_units;
  // on a tie the requester that did not own the display last time wins
  assign win = (&req) ? ~last_owner_q : req[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shown_val_d = shown_val_q;
    owner_d = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: if (|req) begin
        owner_d = win;
        shown_val_d = win ? val1 : val0;
        cnt_d = '0;
        state_d = SHOW;
      end
      SHOW: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? GAP : SHOW;
      end
      GAP: begin
        last_owner_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shown_val_q <= '0;
      owner_q <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shown_val_q <= shown_val_d;
      owner_q <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end
  display_6bit u_dec (.val(shown_val_q), .seg_tens(dec_tens), .seg_units(dec_units));
  assign show = state_q == SHOW;
  assign grant = show ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign done = (show && cnt_q == LAST) ? grant : 2'b00;
  assign busy = state_q != IDLE;
  assign seg_tens = show ? dec_tens : 7'b1111111;
  assign seg_units = show ? dec_units : 7'b1111111;
endmodule
